// File: rtl/rdma_tx_egress_buf_if.sv
// Beat-stream bundle between the RDMA TX path, the egress buffer and the MAC.
// The TX side has no ready; only the MAC side is flow-controlled.
interface rdma_tx_egress_buf_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;

    // master: the environment (TX producer + MAC consumer); slave: the buffer
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output out_valid, out_data, out_last
    );
endinterface

// File: rtl/rdma_tx_egress_buf.sv
// Store-and-forward egress buffer: only whole packets reach the MAC; overflowing packets are dropped.
// Optional macro RDMA_EGRESS_STATS_EN enables the saturating drop/sent packet counters.
module rdma_tx_egress_buf #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rdma_tx_egress_buf_if.slave  bus,
    output logic [ADDR_W:0]      level,
    output logic [15:0]          drop_cnt,
    output logic [15:0]          sent_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_DROP = 2'd2
    } wr_state_e;

    localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

    logic [DATA_W:0]  mem [DEPTH];

    logic [ADDR_W:0]  wr_spec_q, wr_spec_d;
    logic [ADDR_W:0]  wr_cmt_q,  wr_cmt_d;
    logic [ADDR_W:0]  rd_ptr_q,  rd_ptr_d;
    logic [ADDR_W:0]  pkt_cnt_q, pkt_cnt_d;
    wr_state_e        state_q,   state_d;
    logic             out_valid_q, out_valid_d;

    logic [ADDR_W:0]  used;
    logic             full;
    logic             accept;
    logic             wr_fire;
    logic             commit;
    logic             rollback;
    logic             rd_fire;
    logic             rd_last;
    logic [DATA_W:0]  rd_word;

    // Occupancy counts speculative beats so an in-flight packet can never overrun unread data.
    assign used     = wr_spec_q - rd_ptr_q;
    assign full     = (used == DEPTH_P);
    assign accept   = bus.in_valid && (state_q != ST_DROP);
    assign wr_fire  = accept && !full;
    assign commit   = wr_fire && bus.in_last;
    assign rollback = accept && full;

    assign rd_word  = mem[rd_ptr_q[ADDR_W-1:0]];
    assign rd_fire  = out_valid_q && bus.out_ready;
    assign rd_last  = rd_fire && rd_word[DATA_W];

    always_comb begin
        wr_spec_d = wr_spec_q;
        wr_cmt_d  = wr_cmt_q;
        state_d   = state_q;

        if (wr_fire) begin
            wr_spec_d = wr_spec_q + PTR_ONE;
        end
        if (commit) begin
            wr_cmt_d = wr_spec_q + PTR_ONE;
        end
        // Rollback discards the partial packet but leaves committed data untouched.
        if (rollback) begin
            wr_spec_d = wr_cmt_q;
        end

        case (state_q)
            ST_IDLE, ST_PKT: begin
                if (bus.in_valid) begin
                    if (bus.in_last) begin
                        state_d = ST_IDLE;
                    end else if (full) begin
                        state_d = ST_DROP;
                    end else begin
                        state_d = ST_PKT;
                    end
                end
            end
            ST_DROP: begin
                if (bus.in_valid && bus.in_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        pkt_cnt_d = pkt_cnt_q;

        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        // A commit and a last-beat read in the same cycle cancel out.
        case ({commit, rd_last})
            2'b10:   pkt_cnt_d = pkt_cnt_q + PTR_ONE;
            2'b01:   pkt_cnt_d = pkt_cnt_q - PTR_ONE;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase

        out_valid_d = (pkt_cnt_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_spec_q   <= '0;
            wr_cmt_q    <= '0;
            rd_ptr_q    <= '0;
            pkt_cnt_q   <= '0;
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            wr_spec_q   <= wr_spec_d;
            wr_cmt_q    <= wr_cmt_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_cnt_q   <= pkt_cnt_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Storage carries no reset; stale contents are never visible because reads are gated by out_valid.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_spec_q[ADDR_W-1:0]] <= {bus.in_last, bus.in_data};
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_valid_q ? rd_word[DATA_W-1:0] : '0;
    assign bus.out_last  = out_valid_q ? rd_word[DATA_W]     : 1'b0;
    assign level         = wr_cmt_q - rd_ptr_q;

`ifdef RDMA_EGRESS_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [15:0] sent_cnt_q, sent_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        sent_cnt_d = sent_cnt_q;
        if (rollback && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (rd_last && (sent_cnt_q != 16'hFFFF)) begin
            sent_cnt_d = sent_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
            sent_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            sent_cnt_q <= sent_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
    assign sent_cnt = sent_cnt_q;
`else
    assign drop_cnt = 16'h0;
    assign sent_cnt = 16'h0;
`endif

endmodule
